gcd_ctrl: RTL and testbench
===========================

GCD_CTRL -- requirements
Module: gcd_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a computation; sampled only in IDLE.
REQ-005 The block SHALL have port X, input, W bits: first operand, captured on the accepting edge.
REQ-006 The block SHALL have port Y, input, W bits: second operand, captured on the accepting edge.
REQ-007 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-008 The block SHALL have port done, output, 1 bit: one-cycle pulse marking result valid.
REQ-009 The block SHALL have port result, output, W bits: GCD of the captured X and Y, held until the next accepted start.

Function
REQ-010 The FSM SHALL have exactly these states: IDLE, CMP, SUB and FIN.
REQ-011 In IDLE with start=1, the next edge SHALL load x_reg<=X and y_reg<=Y and move to CMP; with start=0 the FSM SHALL stay in IDLE.
REQ-012 In CMP, if x_reg==0 or y_reg==0, the next edge SHALL set result<=x_reg|y_reg and move to FIN; gcd(0,b)=b, gcd(0,0)=0, and the block SHALL never loop forever.
REQ-013 Otherwise in CMP, the next edge SHALL move to SUB when x_neq_y=1 (x_reg!=y_reg), else set result<=x_reg and move to FIN.
REQ-014 In SUB, the next edge SHALL perform y_reg<=y_reg-x_reg when x_lt_y=1, else x_reg<=x_reg-y_reg, and return to CMP.
REQ-015 Each SUB step SHALL update exactly one register; the subtraction SHALL be W-bit unsigned and SHALL never underflow by construction.
REQ-016 In FIN, done SHALL be 1 for exactly that one cycle, and the next edge SHALL return to IDLE.
REQ-017 With k SUB steps, done SHALL be visible after edge 2k+2 counted from the accepting edge (edge 1); the W=4 worst case is gcd(15,1) with k=14, i.e. 30 edges.
REQ-018 start SHALL be ignored while busy=1, including during FIN; X and Y SHALL be don't-care outside the accepting edge.
REQ-019 A start asserted in the IDLE cycle immediately after FIN SHALL be accepted, giving back-to-back operation with one idle cycle between computations.
REQ-020 result SHALL change only on the CMP->FIN edge.

Reset
REQ-021 rst_n=0 SHALL, asynchronously and at any state including mid-computation, force state=IDLE, x_reg=0, y_reg=0, result=0, busy=0 and done=0.
REQ-022 After rst_n deasserts, the first accepted start SHALL behave identically to a start from power-up.

Structure
REQ-023 Package gcd_pkg SHALL hold the state enumeration (IDLE, CMP, SUB, FIN) and the default width constant.
REQ-024 Datapath sub-module gcd_dp SHALL hold x_reg, y_reg, the subtractors, and the x_neq_y and x_lt_y compare flags, and SHALL take load, sel_x_sub and sel_y_sub controls.
REQ-025 gcd_ctrl SHALL contain only the FSM, the result register and the output logic.

Verification
REQ-026 The bench SHALL cover start with X=12, Y=8: done after 6 edges, result=4, busy high for 6 cycles.
REQ-027 The bench SHALL cover X=15, Y=1: done after 30 edges, result=1.
REQ-028 The bench SHALL cover X=9, Y=9: no SUB visited, done after 2 edges, result=9; and X=0, Y=6: result=6 after 2 edges; and X=0, Y=0: result=0 after 2 edges.
REQ-029 The bench SHALL hold start=1 throughout X=12, Y=8 with X/Y changed mid-run: result=4, and a second computation is accepted in the IDLE cycle after FIN.
REQ-030 The bench SHALL pulse rst_n low during SUB of X=15, Y=1: all outputs 0 immediately, and a later X=6, Y=4 yields result=2.
REQ-031 The bench SHALL compare exhaustively against a reference model over all 256 pairs at W=4, checking result and exact done latency.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types and constants for the subtractive GCD controller.
package gcd_pkg;

  localparam int W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    SUB  = 2'd2,
    FIN  = 2'd3
  } state_t;

endpackage

// File: rtl/gcd_dp.sv
// GCD datapath: operand registers, the two subtractors and the compare flags.
module gcd_dp
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         sel_x_sub,
  input  logic         sel_y_sub,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] y_in,
  output logic [W-1:0] x_reg,
  output logic [W-1:0] y_reg,
  output logic         x_neq_y,
  output logic         x_lt_y,
  output logic         any_zero
);

  logic [W-1:0] x_minus_y;
  logic [W-1:0] y_minus_x;

  // Only the subtractor whose result is non-negative is ever selected.
  assign x_minus_y = x_reg - y_reg;
  assign y_minus_x = y_reg - x_reg;

  assign x_neq_y  = (x_reg != y_reg);
  assign x_lt_y   = (x_reg < y_reg);
  assign any_zero = (x_reg == '0) || (y_reg == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg <= '0;
      y_reg <= '0;
    end else if (load) begin
      x_reg <= x_in;
      y_reg <= y_in;
    end else if (sel_x_sub) begin
      x_reg <= x_minus_y;
    end else if (sel_y_sub) begin
      y_reg <= y_minus_x;
    end
  end

endmodule

// File: rtl/gcd_ctrl.sv
// Subtractive GCD controller: sequencing FSM, result register and status outputs.
// state | meaning
// IDLE  | waiting for start, operands loaded on the accepting edge
// CMP   | inspect operands: finish on zero/equal, otherwise subtract
// SUB   | subtract the smaller operand from the larger one
// FIN   | result valid, done pulses for this single cycle
module gcd_ctrl
  import gcd_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] X,
  input  logic [W-1:0] Y,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result
);

  state_t       state, state_nxt;
  logic         load, sel_x_sub, sel_y_sub, result_we;
  logic [W-1:0] x_reg, y_reg;
  logic         x_neq_y, x_lt_y, any_zero;

  gcd_dp #(.W(W)) u_dp (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .sel_x_sub (sel_x_sub),
    .sel_y_sub (sel_y_sub),
    .x_in      (X),
    .y_in      (Y),
    .x_reg     (x_reg),
    .y_reg     (y_reg),
    .x_neq_y   (x_neq_y),
    .x_lt_y    (x_lt_y),
    .any_zero  (any_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    sel_x_sub = 1'b0;
    sel_y_sub = 1'b0;
    result_we = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = CMP;
        end
      end
      CMP: begin
        // Zero operand terminates immediately so gcd(0,0) cannot spin.
        if (any_zero || !x_neq_y) begin
          result_we = 1'b1;
          state_nxt = FIN;
        end else begin
          state_nxt = SUB;
        end
      end
      SUB: begin
        if (x_lt_y) sel_y_sub = 1'b1;
        else        sel_x_sub = 1'b1;
        state_nxt = CMP;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // x|y equals the nonzero operand when one is zero, and x when both are equal.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         result <= '0;
    else if (result_we) result <= x_reg | y_reg;
  end

  assign busy = (state != IDLE);
  assign done = (state == FIN);

endmodule

// File: tb/tb_gcd_ctrl.sv
// Self-checking bench for gcd_ctrl against a Euclid/subtraction-count reference model.
module tb_gcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] X = '0;
  logic [3:0] Y = '0;
  logic       busy, done;
  logic [3:0] result;

  int checks = 0;
  int failures = 0;

  gcd_ctrl #(.W(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .X      (X),
    .Y      (Y),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int model_gcd(input int a, input int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Number of subtract steps the subtractive algorithm needs before the operands meet.
  function automatic int model_steps(input int a, input int b);
    int n = 0;
    if (a == 0 || b == 0) return 0;
    while (a != b) begin
      if (a < b) b = b - a;
      else       a = a - b;
      n++;
    end
    return n;
  endfunction

  // Called at a negedge right after the accepting edge; returns at the negedge where done is seen.
  task automatic wait_done(output int edges, output int busy_cyc);
    edges = 1;
    busy_cyc = 0;
    while (!done && edges < 40) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      edges++;
    end
    if (busy) busy_cyc++;
  endtask

  task automatic run_op(input int a, input int b, input string tag);
    int edges, busy_cyc, exp_edges, exp_res;
    exp_res   = model_gcd(a, b);
    exp_edges = 2 * model_steps(a, b) + 2;
    start = 1'b1;
    X = 4'(a);
    Y = 4'(b);
    @(negedge clk);
    start = 1'b0;
    X = 4'($urandom);
    Y = 4'($urandom);
    wait_done(edges, busy_cyc);
    check_val({tag, "_latency"}, edges, exp_edges);
    check_val({tag, "_result"}, int'(result), exp_res);
    check_val({tag, "_busy_cycles"}, busy_cyc, exp_edges);
    @(negedge clk);
    check_val({tag, "_done_one_cycle"}, int'(done), 0);
    check_val({tag, "_idle_busy"}, int'(busy), 0);
    check_val({tag, "_result_held"}, int'(result), exp_res);
  endtask

  initial begin
    int edges, busy_cyc;

    #12;
    check_val("reset_busy", int'(busy), 0);
    check_val("reset_done", int'(done), 0);
    check_val("reset_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(12, 8, "g12_8");
    run_op(15, 1, "g15_1");
    run_op(9, 9, "g9_9");
    run_op(0, 6, "g0_6");
    run_op(0, 0, "g0_0");

    // start held high with operands changing mid-run, then back-to-back accept.
    start = 1'b1;
    X = 4'd12;
    Y = 4'd8;
    @(negedge clk);
    X = 4'd5;
    Y = 4'd3;
    wait_done(edges, busy_cyc);
    check_val("held_latency", edges, 6);
    check_val("held_result", int'(result), 4);
    @(negedge clk);
    check_val("held_idle_gap", int'(busy), 0);
    @(negedge clk);
    check_val("b2b_accepted", int'(busy), 1);
    start = 1'b0;
    wait_done(edges, busy_cyc);
    check_val("b2b_latency", edges, 2 * model_steps(5, 3) + 2);
    check_val("b2b_result", int'(result), model_gcd(5, 3));
    @(negedge clk);

    // Asynchronous reset while in SUB of gcd(15,1).
    start = 1'b1;
    X = 4'd15;
    Y = 4'd1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_mid_busy", int'(busy), 0);
    check_val("rst_mid_done", int'(done), 0);
    check_val("rst_mid_result", int'(result), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(6, 4, "post_rst_6_4");

    // Exhaustive sweep with random idle gaps and random operand noise.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, "sweep");
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          X = 4'($urandom);
          Y = 4'($urandom);
          @(negedge clk);
        end
      end
    end

    for (int i = 0; i < 20; i++) begin
      run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d expected %0d", 1, 0);
    $fatal(1, "timeout");
  end

endmodule
